// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight, buffers responses in a 2-entry FIFO.
// Optional build macro FETCH_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_1000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instruction
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam logic [1:0]  DEPTH = 2'(BUF_DEPTH);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [1:0]  count_q;
    logic        rd_ptr_q, wr_ptr_q;
    logic        push, pop;

    logic [31:0] buf_pc    [0:1];
    logic [31:0] buf_instr [0:1];

    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign imem_addr = pc_q;

    always_comb begin
        // NOTE: every combinational output is given a default first, so no path can infer a latch.
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        imem_req = 1'b0;
        push     = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = !reset && !redirect_valid && (count_q < DEPTH);
                if (imem_req && imem_ready) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                // A redirect coinciding with the response kills it without needing DRAIN.
                if (redirect_valid) begin
                    state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
        if (redirect_valid) pc_d = {redirect_pc[31:2], 2'b00};
    end

    assign out_valid       = (count_q != 2'd0);
    assign out_pc          = out_valid ? buf_pc[rd_ptr_q] : 32'h0;
    assign out_instruction = out_valid ? buf_instr[rd_ptr_q] : NOP;
    assign pop             = out_valid && !stall_in && !redirect_valid;

    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments so every flop sees pre-edge values.
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= {RESET_PC[31:2], 2'b00};
            req_pc_q <= 32'h0;
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            if (redirect_valid) begin
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
            end else begin
                count_q <= count_q + {1'b0, push} - {1'b0, pop};
                if (push) wr_ptr_q <= ~wr_ptr_q;
                if (pop)  rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // NOTE: the payload array has no reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clock) begin
        if (push) begin
            buf_pc[wr_ptr_q]    <= req_pc_q;
            buf_instr[wr_ptr_q] <= imem_rdata;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= 32'h0;
            perf_bubbles <= 32'h0;
        end else begin
            if (pop)                    perf_fetched <= perf_fetched + 32'd1;
            if (!out_valid && !stall_in) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a memory responder plus address and output scoreboards.
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_1000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } out_t;

    logic        clock;
    logic        reset;
    logic        stall_in;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int checks   = 0;
    int failures = 0;

    int mem_lat     = 1;
    int accepts     = 0;
    int grant_total = 0;
    logic mem_busy  = 1'b0;

    logic [31:0] exp_addr_q [$];
    out_t        exp_out_q  [$];

    assign imem_ready = (accepts < grant_total);

    fetch_stage #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instruction(out_instruction)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubbles   (perf_bubbles)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic expect_fetch(input logic [31:0] a);
        out_t e;
        e.pc    = a;
        e.instr = instr_of(a);
        exp_addr_q.push_back(a);
        exp_out_q.push_back(e);
    endtask

    // Memory responder: one request at a time, response mem_lat cycles after accept.
    initial begin : mem_model
        logic [31:0] acc_addr;
        logic [31:0] exp_a;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clock);
            if (imem_req && imem_ready) begin
                acc_addr = imem_addr;
                mem_busy = 1'b1;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    failures++;
                    $display("FAIL imem_addr: unexpected request addr=%h", acc_addr);
                end else begin
                    exp_a = exp_addr_q.pop_front();
                    if (acc_addr !== exp_a) begin
                        failures++;
                        $display("FAIL imem_addr: got %h expected %h", acc_addr, exp_a);
                    end
                end
                @(posedge clock); #1;
                accepts++;
                repeat (mem_lat - 1) begin
                    @(posedge clock); #1;
                end
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(acc_addr);
                @(posedge clock); #1;
                imem_rvalid = 1'b0;
                imem_rdata  = 32'h0;
                mem_busy    = 1'b0;
            end
        end
    end

    // Output scoreboard: every pop must match the oldest expected entry.
    initial begin : out_monitor
        out_t e;
        forever begin
            @(negedge clock); #2;
            if (!reset && out_valid && !stall_in && !redirect_valid) begin
                checks++;
                if (exp_out_q.size() == 0) begin
                    failures++;
                    $display("FAIL out_stream: unexpected output pc=%h instr=%h", out_pc, out_instruction);
                end else begin
                    e = exp_out_q.pop_front();
                    if (out_pc !== e.pc || out_instruction !== e.instr) begin
                        failures++;
                        $display("FAIL out_stream: got pc=%h instr=%h expected pc=%h instr=%h",
                                 out_pc, out_instruction, e.pc, e.instr);
                    end
                end
            end
        end
    end

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while ((exp_out_q.size() != 0 || exp_addr_q.size() != 0 || mem_busy) && n < max_cycles) begin
            @(negedge clock);
            n++;
        end
        repeat (4) @(negedge clock);
        checks++;
        if (n >= max_cycles) begin
            failures++;
            $display("FAIL drain: timeout, outputs left=%0d requests left=%0d", exp_out_q.size(), exp_addr_q.size());
        end
        @(posedge clock); #1;
    endtask

    task automatic wait_accept(input int target);
        int n = 0;
        while (accepts < target && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (accepts < target) begin
            failures++;
            $display("FAIL accept: timeout, accepts=%0d required=%0d", accepts, target);
        end
    endtask

    task automatic apply_reset();
        int n = 0;
        reset          = 1'b1;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        @(posedge clock); #1;
        while (mem_busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        grant_total = accepts;
        @(posedge clock); #1;
        exp_addr_q.delete();
        exp_out_q.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++;
        if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
        checks++;
        if (out_instruction !== NOP) begin failures++; $display("FAIL reset_instr: got %h expected %h", out_instruction, NOP); end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
            failures++;
            $display("FAIL reset_perf: got fetched=%0d bubbles=%0d expected 0/0", perf_fetched, perf_bubbles);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
            failures++;
            $display("FAIL first_req: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
        end
    endtask

    task automatic test_stream();
        apply_reset();
        mem_lat = 1;
        for (int i = 0; i < 6; i++) expect_fetch(RESET_PC + 32'(4 * i));
        grant_total = accepts + 6;
        wait_drain(200);
    endtask

    task automatic test_stall();
        apply_reset();
        mem_lat  = 1;
        stall_in = 1'b1;
        for (int i = 0; i < 4; i++) expect_fetch(RESET_PC + 32'(4 * i));
        grant_total = accepts + 4;
        repeat (8) @(posedge clock);
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_full: out_valid got %b expected 1", out_valid); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clock);
            checks++;
            if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_req: cycle %0d got %b expected 0", c, imem_req); end
            checks++;
            if (out_pc !== RESET_PC || out_instruction !== instr_of(RESET_PC)) begin
                failures++;
                $display("FAIL stall_hold: cycle %0d got pc=%h instr=%h expected pc=%h instr=%h",
                         c, out_pc, out_instruction, RESET_PC, instr_of(RESET_PC));
            end
        end
        @(posedge clock); #1;
        stall_in = 1'b0;
        wait_drain(200);
    endtask

    task automatic test_redirect_wait();
        int a0;
        apply_reset();
        mem_lat = 4;
        exp_addr_q.push_back(RESET_PC);
        a0 = accepts;
        grant_total = a0 + 1;
        wait_accept(a0 + 1);
        @(posedge clock); #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2002;
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || out_instruction !== NOP) begin
            failures++;
            $display("FAIL redir_flush: got valid=%b instr=%h expected 0/%h", out_valid, out_instruction, NOP);
        end
        checks++;
        if (imem_req !== 1'b0) begin failures++; $display("FAIL redir_drain_req: got %b expected 0", imem_req); end
        expect_fetch(32'h0000_2000);
        expect_fetch(32'h0000_2004);
        grant_total = accepts + 2;
        wait_drain(200);
    endtask

    task automatic test_redirect_rvalid();
        int n = 0;
        apply_reset();
        mem_lat = 2;
        exp_addr_q.push_back(RESET_PC);
        grant_total = accepts + 1;
        while (!imem_rvalid && n < 50) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (!imem_rvalid) begin failures++; $display("FAIL rvalid_wait: timeout, rvalid got 0 expected 1"); end
        #1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        expect_fetch(32'h0000_3000);
        grant_total = accepts + 1;
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0000_3000) begin
            failures++;
            $display("FAIL redir_same_cycle: got req=%b addr=%h expected 1/00003000", imem_req, imem_addr);
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_same_valid: got %b expected 0", out_valid); end
        wait_drain(200);
    endtask

    task automatic test_wrap();
        apply_reset();
        mem_lat        = 1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(posedge clock); #1;
        redirect_valid = 1'b0;
        expect_fetch(32'hFFFF_FFFC);
        expect_fetch(32'h0000_0000);
        expect_fetch(32'h0000_0004);
        grant_total = accepts + 3;
        wait_drain(200);
    endtask

    task automatic test_reset_mid();
        int a0;
        int n = 0;
        apply_reset();
        mem_lat = 4;
        exp_addr_q.push_back(RESET_PC);
        a0 = accepts;
        grant_total = a0 + 1;
        wait_accept(a0 + 1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_outs: got req=%b valid=%b expected 0/0", imem_req, out_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'h0 || perf_bubbles !== 32'h0) begin
            failures++;
            $display("FAIL midreset_perf: got fetched=%0d bubbles=%0d expected 0/0", perf_fetched, perf_bubbles);
        end
`endif
        @(posedge clock); #1;
        reset = 1'b0;
        while (mem_busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RESET_PC || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_restart: got req=%b addr=%h valid=%b expected 1/%h/0",
                     imem_req, imem_addr, out_valid, RESET_PC);
        end
        @(posedge clock); #1;
        expect_fetch(RESET_PC);
        expect_fetch(RESET_PC + 32'd4);
        grant_total = accepts + 2;
        wait_drain(200);
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (perf_fetched !== 32'd2) begin
            failures++;
            $display("FAIL midreset_fetched: got %0d expected 2", perf_fetched);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
